uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Configurable UART receiver for the serial front end. It is the successor to the fixed-format receiver and adds a metastability synchroniser, false-start rejection, 3-sample majority voting, optional even/odd parity, one or two stop bits, framing/parity error flags and break detection. It consumes the shared baud-rate oversampling tick. Its byte/flag outputs feed the UART FIFO and the debug-unit command decoder.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first; range 5..9.
- `SB_TICKS`, default 16: `s_tick` pulses per bit period; even, ≥ 8.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: reset is asynchronous and active-high; clock is `clk`.
- `s_tick` in 1: oversampling strobe, one `clk` wide, SB_TICKS per bit.
- `rx` in 1: asynchronous serial line; idles high.
- `parity_en` in 1: 1 means a parity bit follows the data bits.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even; ignored if `parity_en` = 0.
- `two_stop` in 1: 1 means two stop bits are expected.
- `rx_done_tick` out 1: one-`clk` pulse when a frame completes.
- `dout` out DATA_BITS: last received data word, held until the next `rx_done_tick`.
- `parity_err` out 1: parity mismatch for the frame in `dout`.
- `frame_err` out 1: a stop bit was sampled as 0.
- `break_det` out 1: the frame was a break condition.
- `busy` out 1: high in every state other than IDLE.

## Operation
- **Synchroniser.** `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. Everything below uses `rx_s`.
- **Config latching.** `parity_en`, `parity_odd` and `two_stop` are latched on the IDLE→START transition. Changes mid-frame have no effect on the current frame.
- **Tick counter.** Counter `s` counts `s_tick` pulses. Counter `n` counts bits. A shift register `sh` (DATA_BITS) collects data. All state advances only on cycles where `s_tick` = 1, except IDLE and BRK_WAIT exits.
- **IDLE.** When `rx_s` = 0: set `s` = 0, go to START.
- **START.**
  - At `s` = SB_TICKS/2−1, if `rx_s` = 0: go to DATA with `s` = 0, `n` = 0.
  - At `s` = SB_TICKS/2−1, if `rx_s` = 1: this is a false start. Return to IDLE with no pulse and no flag change.
  - Otherwise increment `s`.
- **Bit sampling (DATA/PARITY/STOP).** Sample `rx_s` at `s` = SB_TICKS−3, SB_TICKS−2 and SB_TICKS−1. The bit value is the majority of the three samples, decided at `s` = SB_TICKS−1. At that point `s` wraps to 0.
- **DATA.**
  - Each decided bit is shifted in MSB-side: `sh` = {bit, `sh`[DATA_BITS−1:1]}.
  - After the bit with `n` = DATA_BITS−1: go to PARITY if `parity_en`, else go to STOP. Set `n` = 0.
- **PARITY.** One bit period. Compute `perr` = ^`sh` ^ bit ^ `parity_odd`. Then go to STOP.
- **STOP.** One bit period per stop bit.
  - If the decided bit = 0: framing error. Complete the frame immediately.
  - If the bit = 1 and it is the last stop bit (the first stop bit when `two_stop` = 0, the second when `two_stop` = 1): complete normally.
  - Otherwise stay in STOP for the second stop bit.
- **Frame completion** (single cycle):
  - Pulse `rx_done_tick`.
  - Load `dout` ← `sh`, `parity_err` ← `perr` (0 if parity disabled), `frame_err` ← stop-bit-zero.
  - Set `break_det` ← `frame_err` AND `sh` = 0 AND (parity bit = 0 or parity disabled).
  - Next state is BRK_WAIT if `break_det`, else IDLE.
- **BRK_WAIT.** Remain until `rx_s` = 1, then go to IDLE. No further frames are reported while the line stays low.
- **Flag holding.** Flags and `dout` change only on frame completion and hold between frames.
- **`busy`.** `busy` = (state ≠ IDLE), registered from the state.
- **Reset.** Reset at any time, including mid-frame, forces IDLE and synchroniser = 1. It clears `s`, `n`, `sh` and the latched config. All outputs go to 0. No pulse is emitted for an aborted frame.

## Timing
- **Reset values:** `rx_done_tick` = 0, `dout` = 0, `parity_err` = 0, `frame_err` = 0, `break_det` = 0, `busy` = 0.
- **Input latency:** 2 `clk` from `rx` to `rx_s`. IDLE→START happens on the first cycle `rx_s` = 0.
- **Normal frame:** `rx_done_tick` fires on the `clk` edge of s_tick number SB_TICKS/2 + SB_TICKS·(DATA_BITS + P + S), counted from START entry. P = `parity_en`, S = 1 + `two_stop`.
- **Early termination:** a frame-error frame that ends on stop bit k completes at s_tick SB_TICKS/2 + SB_TICKS·(DATA_BITS + P + k).
- **Output update:** `dout` and all flags update on the same edge that raises `rx_done_tick`. They are valid while `rx_done_tick` = 1 and hold afterwards.
- **Re-arm:** after a normal completion the block sits in IDLE on the next cycle. It can detect a start bit immediately, with no dead time.
- **Majority rejection:** a single-`s_tick`-wide glitch inside any bit period is rejected.

## Test plan
Bench setup for all scenarios: DATA_BITS = 8, SB_TICKS = 16, `s_tick` every 4 `clk`.

- **Basic frame:** 0xA5, no parity, 1 stop → one `rx_done_tick` 152 ticks after START. `dout` = 0xA5, all flags 0, `busy` low the cycle after.
- **Parity:**
  - 0x3C, even parity, parity bit 0 → `parity_err` = 0.
  - Repeat with parity bit 1 → `parity_err` = 1, `dout` = 0x3C.
  - 0x01, odd parity, parity bit 0 → `parity_err` = 0.
- **False start:** `rx` low for 4 ticks then high → no `rx_done_tick`. `busy` returns to 0 after 8 ticks.
- **Glitch and two stop bits:** 0x5A with one-tick glitches in bits 2 and 6 → `dout` = 0x5A. With `two_stop` = 1 and the second stop bit = 0 → `frame_err` = 1, `dout` = 0x5A, `break_det` = 0.
- **Break:** `rx` held low for 12 bit times → a single `rx_done_tick` with `dout` = 0x00, `frame_err` = 1, `break_det` = 1, and no further pulses. After `rx` returns high, frame 0x55 is received with all flags 0.
- **Reset mid-frame:** `reset` asserted during data bit 4 → all outputs 0 immediately and no pulse. Next frame 0x81 is received with `dout` = 0x81 and flags 0.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
//
// Configurable UART receiver fed by the shared baud oversampling tick.
// It synchronises the serial line and rejects false starts. Each data,
// parity and stop bit is decided by a 3-sample majority vote late in the
// bit period. Parity (even/odd/off) and one or two stop bits are selectable
// per frame. Parity and framing errors are flagged. A break (all-zero frame
// with a zero stop bit) is reported once, and the receiver then waits for
// the line to return high.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high reset
//   s_tick       : oversampling strobe, SB_TICKS pulses per bit period
//   rx           : asynchronous serial input, idles high
//   parity_en    : a parity bit follows the data bits
//   parity_odd   : odd parity when 1, even when 0
//   two_stop     : two stop bits expected when 1
//   rx_done_tick : one-cycle pulse when a frame completes
//   dout         : last received data word (LSB received first)
//   parity_err   : parity mismatch for the word in dout
//   frame_err    : a stop bit was sampled as 0
//   break_det    : the completed frame was a break condition
//   busy         : receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 rx_done_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int SW = $clog2(SB_TICKS);
    localparam int NW = 4;

    localparam logic [SW-1:0] S_HALF  = SW'(SB_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_SAMP1 = SW'(SB_TICKS - 3);
    localparam logic [SW-1:0] S_SAMP2 = SW'(SB_TICKS - 2);
    localparam logic [SW-1:0] S_LAST  = SW'(SB_TICKS - 1);
    localparam logic [SW-1:0] S_ONE   = SW'(1);
    localparam logic [NW-1:0] N_LAST  = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] N_ONE   = NW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    // Synchroniser
    logic rx_meta;
    logic rx_s;

    // State and datapath registers with their next values
    state_t                 state,       state_next;
    logic [SW-1:0]          s,           s_next;
    logic [NW-1:0]          n,           n_next;
    logic [DATA_BITS-1:0]   sh,          sh_next;
    logic                   samp_a,      samp_a_next;
    logic                   samp_b,      samp_b_next;
    logic                   cfg_par_en,  cfg_par_en_next;
    logic                   cfg_par_odd, cfg_par_odd_next;
    logic                   cfg_two_stop, cfg_two_stop_next;
    logic                   perr,        perr_next;
    logic                   par_bit,     par_bit_next;

    // Output next values
    logic                   done_next;
    logic [DATA_BITS-1:0]   dout_next;
    logic                   parity_err_next;
    logic                   frame_err_next;
    logic                   break_det_next;
    logic                   busy_next;

    // Combinational helpers
    logic in_bit_state;
    logic bit_end;
    logic bit_val;
    logic finish;
    logic stop_zero;
    logic brk;

    // Two-flop synchroniser for the asynchronous serial line. Both flops
    // reset to the idle level so that reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register for the receive FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: tick and bit counters, the data shift register,
    // the two early majority samples, per-frame configuration and the
    // parity result carried from the PARITY bit to frame completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s            <= '0;
            n            <= '0;
            sh           <= '0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            cfg_par_en   <= 1'b0;
            cfg_par_odd  <= 1'b0;
            cfg_two_stop <= 1'b0;
            perr         <= 1'b0;
            par_bit      <= 1'b0;
        end else begin
            s            <= s_next;
            n            <= n_next;
            sh           <= sh_next;
            samp_a       <= samp_a_next;
            samp_b       <= samp_b_next;
            cfg_par_en   <= cfg_par_en_next;
            cfg_par_odd  <= cfg_par_odd_next;
            cfg_two_stop <= cfg_two_stop_next;
            perr         <= perr_next;
            par_bit      <= par_bit_next;
        end
    end

    // Registered outputs. The word and the flags only move on frame
    // completion, so they hold steady for the FIFO and decoder in between.
    // busy is loaded from the next state so it always matches the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_done_tick <= done_next;
            dout         <= dout_next;
            parity_err   <= parity_err_next;
            frame_err    <= frame_err_next;
            break_det    <= break_det_next;
            busy         <= busy_next;
        end
    end

    // Next-state and datapath logic. All bit-timed states share one tick
    // counter. Two early samples are captured at SB_TICKS-3 and SB_TICKS-2.
    // The vote with the live sample at SB_TICKS-1 decides the bit, so a
    // glitch one tick wide can corrupt at most one of the three samples.
    always_comb begin
        state_next        = state;
        s_next            = s;
        n_next            = n;
        sh_next           = sh;
        samp_a_next       = samp_a;
        samp_b_next       = samp_b;
        cfg_par_en_next   = cfg_par_en;
        cfg_par_odd_next  = cfg_par_odd;
        cfg_two_stop_next = cfg_two_stop;
        perr_next         = perr;
        par_bit_next      = par_bit;
        done_next         = 1'b0;
        dout_next         = dout;
        parity_err_next   = parity_err;
        frame_err_next    = frame_err;
        break_det_next    = break_det;
        finish            = 1'b0;
        stop_zero         = 1'b0;
        brk               = 1'b0;

        in_bit_state = (state == DATA) || (state == PARITY) || (state == STOP);
        bit_end      = in_bit_state && s_tick && (s == S_LAST);
        bit_val      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

        if (in_bit_state && s_tick) begin
            if (s == S_SAMP1) begin
                samp_a_next = rx_s;
            end
            if (s == S_SAMP2) begin
                samp_b_next = rx_s;
            end
            s_next = (s == S_LAST) ? '0 : s + S_ONE;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next        = START;
                    s_next            = '0;
                    cfg_par_en_next   = parity_en;
                    cfg_par_odd_next  = parity_odd;
                    cfg_two_stop_next = two_stop;
                    perr_next         = 1'b0;
                    par_bit_next      = 1'b0;
                end
            end

            // Check the start bit half a bit period in. A line that has
            // gone back high by then was noise, not a frame.
            START: begin
                if (s_tick) begin
                    if (s == S_HALF) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end

            DATA: begin
                if (bit_end) begin
                    sh_next = {bit_val, sh[DATA_BITS-1:1]};
                    if (n == N_LAST) begin
                        n_next     = '0;
                        state_next = cfg_par_en ? PARITY : STOP;
                    end else begin
                        n_next = n + N_ONE;
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    perr_next    = (^sh) ^ bit_val ^ cfg_par_odd;
                    par_bit_next = bit_val;
                    state_next   = STOP;
                end
            end

            // n counts stop bits here. A zero stop bit ends the frame at
            // once, even if a second stop bit was expected.
            STOP: begin
                if (bit_end) begin
                    if (!bit_val) begin
                        finish    = 1'b1;
                        stop_zero = 1'b1;
                    end else if (!cfg_two_stop || (n == N_ONE)) begin
                        finish = 1'b1;
                    end else begin
                        n_next = n + N_ONE;
                    end
                end
            end

            BRK_WAIT: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Frame completion publishes the word and flags together with the
        // pulse. A break parks the FSM until the line goes high again, so
        // a long low line is reported only once.
        if (finish) begin
            brk             = stop_zero && (sh == '0) && (!cfg_par_en || !par_bit);
            done_next       = 1'b1;
            dout_next       = sh;
            parity_err_next = cfg_par_en & perr;
            frame_err_next  = stop_zero;
            break_det_next  = brk;
            state_next      = brk ? BRK_WAIT : IDLE;
        end

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Self-checking bench for uart_rx_cfg (DATA_BITS = 8, SB_TICKS = 16,
// s_tick every 4 clk). Each frame task pushes the expected word, flags,
// completion tick count and busy level into a scoreboard queue. A monitor
// pops one entry on every rx_done_tick and compares. A pulse with nothing
// expected is reported as a spurious completion.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         ticks;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       break_det;
    logic       busy;

    int   assert_count = 0;
    int   fail_count = 0;
    int   ticks_in_frame = 0;
    exp_t exp_q[$];
    exp_t got_e;

    uart_rx_cfg #(
        .DATA_BITS(8),
        .SB_TICKS (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .rx_done_tick(rx_done_tick),
        .dout        (dout),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det),
        .busy        (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Oversampling strobe: one clk wide, every fourth clk, driven on the
    // falling edge so it is stable at the DUT's rising edge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Count s_tick edges seen while the receiver is busy, i.e. since START
    // entry. On the completion edge this holds the completion tick number.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ticks_in_frame <= 0;
        end else if (!busy) begin
            ticks_in_frame <= 0;
        end else if (s_tick) begin
            ticks_in_frame <= ticks_in_frame + 1;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: on each completion pulse, pop and compare.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                got_e = exp_q.pop_front();
                checkOutput("dout", 32'(dout), 32'(got_e.data));
                checkOutput("parity_err", 32'(parity_err), 32'(got_e.perr));
                checkOutput("frame_err", 32'(frame_err), 32'(got_e.ferr));
                checkOutput("break_det", 32'(break_det), 32'(got_e.brk));
                checkOutput("done_tick_count", 32'(ticks_in_frame), 32'(got_e.ticks));
                checkOutput("busy_after_done", 32'(busy), 32'(got_e.brk));
            end
        end
    end

    // Wait for n s_tick rising edges, then step just past the edge.
    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (s_tick !== 1'b1);
        end
        #1;
    endtask

    // Drive one bit period; an optional one-tick inverted glitch lands on
    // the middle one of the receiver's three sample points.
    task automatic driveBit(input logic val, input logic glitch);
        rx = val;
        if (glitch) begin
            waitTicks(6);
            rx = ~val;
            waitTicks(1);
            rx = val;
            waitTicks(9);
        end else begin
            waitTicks(16);
        end
    endtask

    // Send one frame and push its expected result. The first stop bit is
    // always high. A low second stop bit is released right after its
    // decision point so the line is idle again for the next frame.
    task automatic applyStimulus(input logic [7:0] data, input logic par_en,
                                 input logic par_odd, input logic par_bit,
                                 input logic two_st, input logic stop2,
                                 input logic [7:0] glitch);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(data[i]);
        end
        ones += int'(par_bit);
        e.data  = data;
        // Even parity wants an even count of ones, odd parity an odd count.
        e.perr  = par_en && ((ones % 2 == 1) != par_odd);
        e.ferr  = two_st && !stop2;
        e.brk   = e.ferr && (data == 8'h00) && (!par_en || !par_bit);
        e.ticks = 8 + 16 * (8 + int'(par_en) + 1 + int'(two_st));
        parity_en  = par_en;
        parity_odd = par_odd;
        two_stop   = two_st;
        exp_q.push_back(e);

        waitTicks(1);
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            driveBit(data[i], glitch[i]);
        end
        if (par_en) begin
            driveBit(par_bit, 1'b0);
        end
        driveBit(1'b1, 1'b0);
        if (two_st) begin
            if (stop2) begin
                driveBit(1'b1, 1'b0);
            end else begin
                rx = 1'b0;
                waitTicks(8);
                rx = 1'b1;
                waitTicks(8);
            end
        end
        rx = 1'b1;
        waitTicks(12);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d frames still expected", exp_q.size());
        $fatal(1, "[TB] timeout");
    end

    // Main stimulus sequence.
    initial begin
        exp_t e;
        $display("[TB] uart_rx_cfg bench start");

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_done", 32'(rx_done_tick), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_break_det", 32'(break_det), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        waitTicks(4);

        // Basic frame, then parity variants
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // False start: low for 4 ticks, then high
        parity_en = 1'b0;
        two_stop  = 1'b0;
        waitTicks(1);
        rx = 1'b0;
        waitTicks(4);
        checkOutput("false_start_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        waitTicks(5);
        checkOutput("false_start_idle", 32'(busy), 32'd0);
        waitTicks(8);

        // Glitched frame with a zero second stop bit, then a clean two-stop frame
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Break: line low for 12 bit times
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        e.data  = 8'h00;
        e.perr  = 1'b0;
        e.ferr  = 1'b1;
        e.brk   = 1'b1;
        e.ticks = 8 + 16 * 9;
        exp_q.push_back(e);
        waitTicks(1);
        rx = 1'b0;
        waitTicks(12 * 16);
        checkOutput("break_wait_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        waitTicks(16);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Reset during data bit 4
        waitTicks(1);
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 4; i++) begin
            driveBit(1'b1, 1'b0);
        end
        rx = 1'b0;
        waitTicks(8);
        checkOutput("mid_frame_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_done", 32'(rx_done_tick), 32'd0);
        checkOutput("midreset_dout", 32'(dout), 32'd0);
        checkOutput("midreset_parity_err", 32'(parity_err), 32'd0);
        checkOutput("midreset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("midreset_break_det", 32'(break_det), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        waitTicks(4);
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // Drain: every expected frame must have completed
        waitTicks(20);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
